// File: rtl/la_seq_pkg.sv
// la_seq_pkg: opcode and state enums, command field positions and status bit
// indices shared by the LA command sequencer and its testable sub-blocks.
package la_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_ADD   = 3'd2,
    OP_READ  = 3'd3,
    OP_ADDI  = 3'd4,
    OP_RSV5  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_CTRL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2
  } state_e;

  localparam int FIELD_W = 3;
  localparam int OP_LSB  = 29;
  localparam int RD_LSB  = 26;
  localparam int RS1_LSB = 23;
  localparam int RS2_LSB = 20;
  localparam int CLR_BIT = 0;

  localparam int ST_BUSY      = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_ILLEGAL   = 2;
  localparam int ST_TIMEOUT   = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 4;

  typedef struct packed {
    op_e         op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [31:0] imm;
  } cmd_entry_t;

  function automatic logic is_legal_op(input op_e op);
    return (op == OP_WRITE) || (op == OP_ADD) || (op == OP_READ) || (op == OP_ADDI);
  endfunction

  function automatic cmd_entry_t decode_cmd(input logic [31:0] cmd, input logic [31:0] imm);
    cmd_entry_t e;
    e.op  = op_e'(cmd[OP_LSB +: FIELD_W]);
    e.rd  = cmd[RD_LSB +: FIELD_W];
    e.rs1 = cmd[RS1_LSB +: FIELD_W];
    e.rs2 = cmd[RS2_LSB +: FIELD_W];
    e.imm = imm;
    return e;
  endfunction

endpackage

// File: rtl/la_seq_fifo.sv
// la_seq_fifo: synchronous register-based queue with occupancy count.
// A push on a full queue is accepted only when a pop happens in the same cycle.
module la_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/la_cmd_sequencer.sv
// la_cmd_sequencer: queues toggle-strobed LA commands and issues them one at a
// time to a datapath. Define SEQ_TIMEOUT_EN to enable the WAIT_RESP watchdog.
module la_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] la_cmd_i,
  input  logic [31:0] la_imm_i,
  input  logic        la_strobe_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [2:0]  cmd_op_o,
  output logic [2:0]  cmd_rd_o,
  output logic [2:0]  cmd_rs1_o,
  output logic [2:0]  cmd_rs2_o,
  output logic [31:0] cmd_imm_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_data_i,
  output logic [31:0] result_o,
  output logic [7:0]  status_o
);

  import la_seq_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(cmd_entry_t);

  state_e        state;
  op_e           in_op;
  cmd_entry_t    in_entry;
  cmd_entry_t    head;
  logic [EW-1:0] head_bits;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          strobe_q;
  logic          sticky_ovf;
  logic          sticky_ill;
  logic          timeout_flag;
  logic          strobe_evt;
  logic          clear_evt;
  logic          illegal_evt;
  logic          push_req;
  logic          pop_req;
  logic          overflow_evt;
  logic          tmo_hit;
  logic          busy;
  logic [4:0]    count_ext;
  logic [3:0]    count_disp;
  logic          unused_cmd_bits;

  assign in_op        = op_e'(la_cmd_i[OP_LSB +: FIELD_W]);
  assign in_entry     = decode_cmd(la_cmd_i, la_imm_i);
  assign strobe_evt   = (la_strobe_i != strobe_q);
  assign clear_evt    = strobe_evt && (in_op == OP_CTRL) && la_cmd_i[CLR_BIT];
  assign illegal_evt  = strobe_evt && !is_legal_op(in_op) && (in_op != OP_NOP) && !clear_evt;
  assign push_req     = strobe_evt && is_legal_op(in_op);
  assign pop_req      = cmd_valid_o && cmd_ready_i;
  // A full queue still takes a new command when the head leaves in the same cycle.
  assign overflow_evt = push_req && fifo_full && !pop_req;
  assign unused_cmd_bits = |la_cmd_i[RS2_LSB-1:CLR_BIT+1];

  la_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (in_entry),
    .rdata (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = cmd_entry_t'(head_bits);

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == S_WAIT_RESP) && !resp_valid_i && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_WAIT_RESP) ? tmo_cnt + 1'b1 : '0;
      if (clear_evt)    timeout_flag <= 1'b0;
      else if (tmo_hit) timeout_flag <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      strobe_q   <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_ill <= 1'b0;
    end else begin
      strobe_q <= la_strobe_i;
      if (clear_evt) begin
        sticky_ovf <= 1'b0;
        sticky_ill <= 1'b0;
      end else begin
        if (overflow_evt) sticky_ovf <= 1'b1;
        if (illegal_evt)  sticky_ill <= 1'b1;
      end
    end
  end

  // cmd_* are captured from the queue head on entry to ISSUE and held until accepted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state       <= S_IDLE;
      cmd_valid_o <= 1'b0;
      cmd_op_o    <= '0;
      cmd_rd_o    <= '0;
      cmd_rs1_o   <= '0;
      cmd_rs2_o   <= '0;
      cmd_imm_o   <= '0;
      result_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state       <= S_ISSUE;
            cmd_valid_o <= 1'b1;
            cmd_op_o    <= head.op;
            cmd_rd_o    <= head.rd;
            cmd_rs1_o   <= head.rs1;
            cmd_rs2_o   <= head.rs2;
            cmd_imm_o   <= head.imm;
          end
        end
        S_ISSUE: begin
          if (cmd_ready_i) begin
            state       <= S_WAIT_RESP;
            cmd_valid_o <= 1'b0;
          end
        end
        S_WAIT_RESP: begin
          if (resp_valid_i) begin
            result_o <= resp_data_i;
            state    <= S_IDLE;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          cmd_valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign count_ext  = 5'(fifo_count);
  assign count_disp = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    status_o = '0;
    status_o[ST_BUSY]     = busy;
    status_o[ST_OVERFLOW] = sticky_ovf;
    status_o[ST_ILLEGAL]  = sticky_ill;
    status_o[ST_TIMEOUT]  = timeout_flag;
    status_o[ST_COUNT_LSB +: ST_COUNT_W] = count_disp;
  end

endmodule

// File: tb/tb_la_cmd_sequencer.sv
// tb_la_cmd_sequencer: scoreboard bench for la_cmd_sequencer; expected commands
// are queued at strobe time and compared when the datapath handshake occurs.
module tb_la_cmd_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] la_cmd = '0;
  logic [31:0] la_imm = '0;
  logic        la_strobe = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rs1;
  logic [2:0]  cmd_rs2;
  logic [31:0] cmd_imm;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic [31:0] result;
  logic [7:0]  status;

  int          tests = 0;
  int          fails = 0;
  logic [43:0] exp_q[$];
  logic [43:0] sb_front;
  logic        exp_ovf = 1'b0;
  logic        exp_ill = 1'b0;

  always #5 clk = ~clk;

  la_cmd_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (255)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst_n),
    .la_cmd_i     (la_cmd),
    .la_imm_i     (la_imm),
    .la_strobe_i  (la_strobe),
    .cmd_valid_o  (cmd_valid),
    .cmd_ready_i  (cmd_ready),
    .cmd_op_o     (cmd_op),
    .cmd_rd_o     (cmd_rd),
    .cmd_rs1_o    (cmd_rs1),
    .cmd_rs2_o    (cmd_rs2),
    .cmd_imm_o    (cmd_imm),
    .resp_valid_i (resp_valid),
    .resp_data_i  (resp_data),
    .result_o     (result),
    .status_o     (status)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one strobe and update the reference queue and sticky flags.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input logic [31:0] imm, input logic bit0);
    la_cmd    = {op, rd, rs1, rs2, 19'd0, bit0};
    la_imm    = imm;
    la_strobe = ~la_strobe;
    if (op >= 3'd1 && op <= 3'd4) begin
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back({op, rd, rs1, rs2, imm});
    end else if (op == 3'd7 && bit0) begin
      exp_ovf = 1'b0;
      exp_ill = 1'b0;
    end else if (op != 3'd0) begin
      exp_ill = 1'b1;
    end
    tick();
  endtask

  task automatic issueOne();
    int n = 0;
    while (!cmd_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("issue_seen", cmd_valid, 1'b1);
    cmd_ready = 1'b1;
    tick();
    checkOutput("accept_drops_valid", cmd_valid, 1'b0);
  endtask

  task automatic respond(input logic [31:0] data);
    resp_valid = 1'b1;
    resp_data  = data;
    tick();
    resp_valid = 1'b0;
    checkOutput("result", result, data);
  endtask

  // Scoreboard: a handshake is visible at the falling edge before it completes.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_spurious_issue", 64'(exp_q.size()), 64'd1);
      end else begin
        sb_front = exp_q.pop_front();
        checkOutput("sb_issue", {cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm}, sb_front);
      end
    end
  end

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick();
    tick();
    checkOutput("rst_valid", cmd_valid, 1'b0);
    checkOutput("rst_status", status, 8'h00);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_cmd", {cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm}, 44'h0);
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    tick();

    // WRITE rd=3 imm=0x1234: valid appears two edges after the strobe.
    applyStimulus(3'd1, 3'd3, 3'd0, 3'd0, 32'h1234, 1'b0);
    checkOutput("lat_valid_n", cmd_valid, 1'b0);
    checkOutput("lat_count_n", status[7:4], 4'd1);
    tick();
    checkOutput("lat_valid_n1", cmd_valid, 1'b1);
    checkOutput("write_op", cmd_op, 3'd1);
    checkOutput("write_rd", cmd_rd, 3'd3);
    checkOutput("write_imm", cmd_imm, 32'h1234);
    tick();
    checkOutput("wait_valid", cmd_valid, 1'b0);
    checkOutput("wait_busy", status[0], 1'b1);
    respond(32'h55);

    // Five strobes while stalled: four queue up, the fifth overflows.
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(3'd2, 3'(i + 1), 3'(i), 3'(7 - i), 32'h100 + i, 1'b0);
    checkOutput("full_count", status[7:4], 4'd4);
    checkOutput("full_ovf", status[1], exp_ovf);
    checkOutput("full_busy", status[0], 1'b1);
    for (int i = 0; i < 4; i++) begin
      issueOne();
      respond(32'hA0 + i);
    end
    checkOutput("drain_busy", status[0], 1'b0);
    checkOutput("drain_sb", 64'(exp_q.size()), 64'd0);

    // ADD completing with 0xDEADBEEF, then a stray response in IDLE.
    applyStimulus(3'd2, 3'd5, 3'd1, 3'd2, 32'h0, 1'b0);
    issueOne();
    respond(32'hDEADBEEF);
    checkOutput("add_busy", status[0], 1'b0);
    resp_valid = 1'b1;
    resp_data  = 32'hBAD0BAD0;
    tick();
    resp_valid = 1'b0;
    checkOutput("idle_resp_ignored", result, 32'hDEADBEEF);

    // NOP, illegal ops and the sticky clear command.
    applyStimulus(3'd0, 3'd1, 3'd1, 3'd1, 32'h9, 1'b0);
    checkOutput("nop_status", status[3:0], {1'b0, exp_ill, exp_ovf, 1'b0});
    applyStimulus(3'd6, 3'd0, 3'd0, 3'd0, 32'h0, 1'b0);
    checkOutput("op6_status", status, {4'd0, 1'b0, exp_ill, exp_ovf, 1'b0});
    applyStimulus(3'd7, 3'd0, 3'd0, 3'd0, 32'h0, 1'b1);
    checkOutput("clear_status", status[3:0], 4'h0);
    applyStimulus(3'd7, 3'd0, 3'd0, 3'd0, 32'h0, 1'b0);
    checkOutput("op7_illegal", status[2], exp_ill);
    applyStimulus(3'd7, 3'd0, 3'd0, 3'd0, 32'h0, 1'b1);
    checkOutput("clear_again", status[3:0], 4'h0);

    // Reset while waiting for a response abandons the command.
    applyStimulus(3'd3, 3'd0, 3'd4, 3'd0, 32'h0, 1'b0);
    issueOne();
    checkOutput("pre_rst_busy", status[0], 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_status", status, 8'h00);
    checkOutput("arst_result", result, 32'h0);
    checkOutput("arst_valid", cmd_valid, 1'b0);
    la_strobe = 1'b0;
    exp_ovf   = 1'b0;
    exp_ill   = 1'b0;
    tick();
    tick();
    rst_n      = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'h777;
    tick();
    resp_valid = 1'b0;
    checkOutput("post_rst_result", result, 32'h0);
    checkOutput("post_rst_status", status, 8'h00);

    // Long silence in WAIT_RESP.
    applyStimulus(3'd1, 3'd2, 3'd0, 3'd0, 32'hCAFE, 1'b0);
    issueOne();
    repeat (300) tick();
`ifdef SEQ_TIMEOUT_EN
    checkOutput("tmo_flag", status[3], 1'b1);
    checkOutput("tmo_idle", status[0], 1'b0);
    checkOutput("tmo_result", result, 32'h0);
    applyStimulus(3'd4, 3'd6, 3'd3, 3'd0, 32'h42, 1'b0);
    issueOne();
    respond(32'h1111);
`else
    checkOutput("no_tmo_flag", status[3], 1'b0);
    checkOutput("no_tmo_busy", status[0], 1'b1);
    respond(32'h2222);
`endif
    checkOutput("final_busy", status[0], 1'b0);
    checkOutput("final_sb", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
